// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, bit-period defaults and counter sizing helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH, PARITY} state_t;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_HALF_BIT = DEF_CLKS_PER_BIT / 2;
  localparam int DATA_BITS = 8;
  function automatic int half_bit(input int clks);
    return clks / 2;
  endfunction
  function automatic int cnt_width(input int clks);
    return $clog2(clks);
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: 2-flop synchroniser (clk, rst active-low async, d -> q) with RST_VAL preset
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ff <= {2{RST_VAL}};
    else ff <= {ff[0], d};
  assign q = ff[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART rx (rxd -> data/valid/frame_err/busy, rst active-low async); UART_RX_PARITY_EN adds 8E1 and parity_err
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n, data_n;
  logic valid_n, ferr_n, rxs;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr_n;
`endif
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxs));
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      data <= data_n;
      valid <= valid_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par <= par_n;
      parity_err <= perr_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    data_n = data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : START;
      end
      START: if (cnt == HALF_END) begin
        cnt_n = '0;
        bit_n = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_END) begin
        cnt_n = '0;
        shift_n[bit_idx] = rxs;
        bit_n = bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_n = bit_idx == LAST_BIT ? PARITY : DATA;
`else
        state_n = bit_idx == LAST_BIT ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == BIT_END) begin
        cnt_n = '0;
        par_n = rxs;
        state_n = STOP;
      end
`endif
      STOP: if (cnt == BIT_END) begin
        cnt_n = '0;
        state_n = rxs ? IDLE : WAIT_HIGH;
        ferr_n = !rxs;
`ifdef UART_RX_PARITY_EN
        perr_n = rxs && ^{shift, par};
        valid_n = rxs && !(^{shift, par});
`else
        valid_n = rxs;
`endif
        data_n = valid_n ? shift : data;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : WAIT_HIGH;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver at 16 clocks per bit
module tb_uart_receiver;
  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  logic par_bad = 1'b0;
  int n_perr = 0;
`endif
  int checks = 0, failures = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, n_both = 0, n_busy = 0, t_valid = 0, t_fall = 0;
  logic busy_q = 1'b0;
  logic [7:0] rx_q[$];
  always #5 clk = ~clk;
  uart_receiver #(.CLKS_PER_BIT(16)) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid) begin
      rx_q.push_back(data);
      n_valid++;
      t_valid = cyc;
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_both++;
    if (busy) n_busy++;
    if (busy_q && !busy) t_fall = cyc;
    busy_q = busy;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic v);
    rxd = v;
    tick(16);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ par_bad);
`endif
    send_bit(stop);
  endtask
  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask
  task automatic test_single;
    int v0 = n_valid, f0 = n_ferr;
    logic [7:0] got;
    send_byte(8'hA5, 1'b1);
    tick(4);
    got = rx_q.size() > v0 ? rx_q[v0] : 8'hxx;
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL single_valid_cnt got=%0d exp=1", n_valid - v0); end
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", got); end
    checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (t_fall - t_valid < 0 || t_fall - t_valid > 1) begin failures++; $display("FAIL single_busy_fall got=%0d exp=0..1", t_fall - t_valid); end
  endtask
  task automatic test_back_to_back;
    int v0 = n_valid, f0 = n_ferr;
    logic [7:0] exp_b[3] = '{8'h00, 8'hFF, 8'h55};
    logic [7:0] got;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
    tick(4);
    checks++; if (n_valid - v0 !== 3) begin failures++; $display("FAIL b2b_valid_cnt got=%0d exp=3", n_valid - v0); end
    for (int i = 0; i < 3; i++) begin
      got = rx_q.size() > v0 + i ? rx_q[v0 + i] : 8'hxx;
      checks++; if (got !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got, exp_b[i]); end
    end
    checks++; if (n_ferr - f0 !== 0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", n_ferr - f0); end
  endtask
  task automatic test_frame_err;
    int v0 = n_valid, f0 = n_ferr;
    logic [7:0] b = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rxd = 1'b0;
    tick(40);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_busy got=%b exp=1", busy); end
    checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL ferr_cnt got=%0d exp=1", n_ferr - f0); end
    rxd = 1'b1;
    tick(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_idle_busy got=%b exp=0", busy); end
    checks++; if (n_valid - v0 !== 0) begin failures++; $display("FAIL ferr_valid_cnt got=%0d exp=0", n_valid - v0); end
    checks++; if (data !== 8'h55) begin failures++; $display("FAIL ferr_data_kept got=%h exp=55", data); end
    send_byte(8'h81, 1'b1);
    tick(4);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL after_ferr_valid_cnt got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h81) begin failures++; $display("FAIL after_ferr_data got=%h exp=81", data); end
  endtask
  task automatic test_glitch;
    int v0 = n_valid, f0 = n_ferr, b0 = n_busy;
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(15);
    checks++; if (n_busy - b0 !== 8) begin failures++; $display("FAIL glitch_busy_cycles got=%0d exp=8", n_busy - b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d/%0d exp=0/0", n_valid - v0, n_ferr - f0); end
  endtask
  task automatic test_reset_mid;
    int v0 = n_valid, f0 = n_ferr;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    rxd = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tick(3);
    rst = 1'b1;
    tick(20);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin failures++; $display("FAIL rstmid_strobes got=%0d/%0d exp=0/0", n_valid - v0, n_ferr - f0); end
    send_byte(8'h7E, 1'b1);
    tick(4);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL rstmid_next_cnt got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h7E) begin failures++; $display("FAIL rstmid_next_data got=%h exp=7e", data); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0 = n_valid, p0 = n_perr;
    par_bad = 1'b0;
    send_byte(8'h07, 1'b1);
    tick(4);
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL par_ok_valid got=%0d exp=1", n_valid - v0); end
    checks++; if (data !== 8'h07) begin failures++; $display("FAIL par_ok_data got=%h exp=07", data); end
    checks++; if (n_perr - p0 !== 0) begin failures++; $display("FAIL par_ok_perr got=%0d exp=0", n_perr - p0); end
    par_bad = 1'b1;
    send_byte(8'h07, 1'b1);
    tick(4);
    par_bad = 1'b0;
    checks++; if (n_perr - p0 !== 1) begin failures++; $display("FAIL par_bad_perr got=%0d exp=1", n_perr - p0); end
    checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL par_bad_valid got=%0d exp=1", n_valid - v0); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (n_both !== 0) begin failures++; $display("FAIL valid_and_ferr got=%0d exp=0", n_both); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. Directly downstream of UART_Transmitter: consumes its `txd` line and recovers 8-bit bytes.
- Frame format: 8N1. LSB first, one start bit (0), one stop bit (1).
- Mid-bit sampling with a fixed clocks-per-bit divider. No backpressure.
- Each received byte appears with a single-cycle valid strobe; framing errors are flagged.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Must be >= 4. Bench uses 16.
- DATA_BITS, 8, payload width. Fixed at 8 in this revision.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- rxd  in  1  serial input, idle high, asynchronous to clk
- data  out  8  last correctly received byte
- valid  out  1  one-cycle strobe: data updated this cycle
- frame_err  out  1  one-cycle strobe: stop bit sampled as 0
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bit counter and clock counter = 0; shift register = 0.
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - Synchroniser flops preset to 1 (idle line).
  - Reset mid-frame abandons the frame; no valid or frame_err is issued.
- rxd passes through a 2-flop synchroniser. All decisions use the synchronised `rxs`, which lags rxd by 2 clk.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rxs=0, go to START with clk counter cleared.
- START: count CLKS_PER_BIT/2 cycles (integer division), then sample rxs.
  - rxs=1: glitch; return to IDLE, no outputs.
  - rxs=0: clear counter, go to DATA with bit index 0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into shift[bit_idx]. Bit 0 is received first.
  - After the sample with bit_idx=7, clear counter and go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs=1: data <= shift and valid=1 on the next edge, then IDLE.
  - rxs=0: frame_err=1 on the next edge, data unchanged, then WAIT_HIGH.
- WAIT_HIGH: remain until rxs=1, then IDLE. This prevents a held-low line (break) from retriggering frames.
- valid and frame_err are registered, asserted for exactly 1 clk, and never both high.
- Back-to-back frames: a start edge arriving in the cycle immediately after the return to IDLE is accepted. There is no idle gap requirement.
- Overrun: data is overwritten by the next good frame. The consumer must capture data on valid.
- Latency: valid rises ≈ 2 + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT + 1 clk after the rxd start-bit falling edge.
- rxd held low at reset release: treated as a start bit. It ends in frame_err, then WAIT_HIGH.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - Frame is 8E1. A PARITY state between DATA and STOP samples the parity bit one bit period after bit 7.
  - Adds output `parity_err` (1-bit, one-cycle strobe). It is asserted, in place of valid, when the XOR of the 8 data bits and the parity bit is 1.
  - On parity_err, data is not updated. parity_err resets to 0.
  - A frame with both a parity error and a bad stop bit reports frame_err only.
- Without the macro: no PARITY state and no parity_err port. Behaviour is exactly 8N1 as above.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP, WAIT_HIGH, PARITY
  - localparam for the half-bit count (CLKS_PER_BIT/2)
  - counter width function (clog2 of CLKS_PER_BIT)
- The package is shared with UART_Transmitter for the bit-period constant.
- One sub-module: uart_sync2, a 2-flop synchroniser. Its parameter is the reset value, and it uses the same clk and active-low asynchronous rst.

Test Plan (CLKS_PER_BIT=16, bench-driven serial model, also looped back from UART_Transmitter txd):
- Single byte 8'hA5, 8N1 → exactly one valid pulse, data=8'hA5, frame_err never high, busy falls within 1 clk after valid.
- Back-to-back 8'h00, 8'hFF, 8'h55 with zero idle bits → three valid pulses in order, matching data, no frame_err.
- Byte 8'h3C with stop bit driven 0, then line returns high after 40 clk → one frame_err pulse, no valid, data keeps its previous value. The next frame 8'h81 is received correctly.
- rxd low glitch of 5 clk in idle → no valid or frame_err; returns to IDLE within 2+8 clk; busy pulses only during START.
- rst asserted (low) for 3 clk in the middle of DATA of byte 8'hC3 → outputs zero immediately (asynchronous), no strobe. A following clean 8'h7E is received correctly.
- With UART_RX_PARITY_EN: 8'h07 sent with parity=1 (even, correct) → valid and data=8'h07. Then parity=0 → parity_err pulse, no valid.
